// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: small first-word-fall-through command FIFO that feeds an
// 8-bit rotate-right barrel shifter. Left rotates are folded into the
// equivalent right-rotate amount as they are written, so the head entry can
// drive the shifter inputs directly.
module shift_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [2:0]       in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       datain,
    output logic [2:0]       shift_amt,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [2:0]       wr_amt;

    // Per-entry read views, gathered so the head can be muxed by rd_ptr_q.
    logic [7:0]       entry_data [DEPTH];
    logic [2:0]       entry_amt  [DEPTH];

    // Status flags depend only on registered occupancy, so a pop cannot
    // open a slot for a push in the same cycle.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        in_ready  = !full;
        out_valid = !empty;
    end

    // Handshake qualification and write-side amount normalisation; a flush
    // cycle discards both the push and the pop.
    always_comb begin
        push   = in_valid && !full && !flush;
        pop    = out_ready && !empty && !flush;
        // Left rotate by n is right rotate by (8 - n) mod 8: a 3-bit negate.
        wr_amt = in_dir ? 3'(3'd0 - in_amt) : in_amt;
    end

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // One storage slot per entry, written when it is the push target.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic       we;
            logic [7:0] data_q, data_d;
            logic [2:0] amt_q, amt_d;

            // Slot write-enable decode and hold-or-load next value.
            always_comb begin
                we     = push && (wr_ptr_q == PTR_W'(gi));
                data_d = we ? in_data : data_q;
                amt_d  = we ? wr_amt  : amt_q;
            end

            // Slot storage; cleared on reset only for tidy simulation.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    amt_q  <= '0;
                end else begin
                    data_q <= data_d;
                    amt_q  <= amt_d;
                end
            end

            assign entry_data[gi] = data_q;
            assign entry_amt[gi]  = amt_q;
        end
    endgenerate

    // Head entry drives the shifter; forced to zero while the queue is empty
    // so the asynchronous clear of count_q also clears these outputs.
    always_comb begin
        datain    = 8'h00;
        shift_amt = 3'd0;
        if (!empty) begin
            datain    = entry_data[rd_ptr_q];
            shift_amt = entry_amt[rd_ptr_q];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Directed bench for shift_cmd_queue with a behavioural rotate-right model
// standing in for the downstream shifter.
module tb_shift_cmd_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [2:0]       in_amt;
    logic             in_dir;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       datain;
    logic [2:0]       shift_amt;
    logic [CNT_W-1:0] count;

    int n_checks;
    int n_fail;

    shift_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .datain    (datain),
        .shift_amt (shift_amt),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotr(input logic [7:0] d, input logic [2:0] a);
        logic [15:0] dd;
        dd = {d, d} >> a;
        return dd[7:0];
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_data   = 8'h00;
        in_amt    = 3'd0;
        in_dir    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 ||
            datain !== 8'h00 || shift_amt !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b count=%0d datain=%h amt=%0d, required 0 1 0 00 0",
                     out_valid, in_ready, count, datain, shift_amt);
        end
        rst_n = 1'b1;
        step();
        $display("reset released: count=%0d", count);
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hB4; in_amt = 3'd3; in_dir = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || datain !== 8'h00) begin
            n_fail++;
            $display("FAIL single_no_bypass: valid=%b datain=%h, required 0 00", out_valid, datain);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || datain !== 8'hB4 || shift_amt !== 3'd3 ||
            rotr(datain, shift_amt) !== 8'h96 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_head: valid=%b datain=%h amt=%0d rot=%h count=%0d, required 1 b4 3 96 1",
                     out_valid, datain, shift_amt, rotr(datain, shift_amt), count);
        end
        $display("single push: datain=%h amt=%0d rot=%h", datain, shift_amt, rotr(datain, shift_amt));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || datain !== 8'h00 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_pop: valid=%b datain=%h count=%0d, required 0 00 0", out_valid, datain, count);
        end
        $display("single pop: valid=%b datain=%h", out_valid, datain);
    endtask

    task automatic test_left_norm();
        logic [2:0] exp_amt [3];
        logic [7:0] exp_rot [3];
        exp_amt[0] = 3'd7; exp_rot[0] = 8'h03;
        exp_amt[1] = 3'd0; exp_rot[1] = 8'h81;
        exp_amt[2] = 3'd5; exp_rot[2] = 8'h0C;   // 8'h81 rotl 3 = 8'h0C
        in_valid = 1'b1; in_data = 8'h81; in_dir = 1'b1;
        in_amt = 3'd1; step();
        in_amt = 3'd0; step();
        in_amt = 3'd3; step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (shift_amt !== exp_amt[i] || rotr(datain, shift_amt) !== exp_rot[i]) begin
                n_fail++;
                $display("FAIL left_norm_%0d: amt=%0d rot=%h, required %0d %h",
                         i, shift_amt, rotr(datain, shift_amt), exp_amt[i], exp_rot[i]);
            end
            $display("left norm %0d: amt=%0d rot=%h", i, shift_amt, rotr(datain, shift_amt));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL left_norm_drain: count=%0d valid=%b, required 0 0", count, out_valid);
        end
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_amt = 3'd0; in_dir = 1'b0;
            step();
        end
        n_checks++;
        if (count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_full: count=%0d ready=%b valid=%b, required 4 0 1", count, in_ready, out_valid);
        end
        in_data = 8'h05;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (count !== 3'd4 || datain !== 8'h01) begin
            n_fail++;
            $display("FAIL fill_overflow: count=%0d head=%h, required 4 01", count, datain);
        end
        $display("full: count=%0d ready=%b", count, in_ready);
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (datain !== 8'(i) || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_order_%0d: datain=%h valid=%b, required %h 1", i, datain, out_valid, 8'(i));
            end
            $display("drain %0d: datain=%h", i, datain);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || datain !== 8'h00) begin
            n_fail++;
            $display("FAIL drain_empty: count=%0d valid=%b datain=%h, required 0 0 00", count, out_valid, datain);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i); in_amt = 3'd0; in_dir = 1'b0;
            step();
        end
        in_data = 8'h14; out_ready = 1'b1;
        step();
        n_checks++;
        if (count !== 3'd3 || datain !== 8'h11 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pushpop: count=%0d head=%h ready=%b, required 3 11 1", count, datain, in_ready);
        end
        $display("full push+pop: count=%0d head=%h", count, datain);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_refill: count=%0d, required 4", count);
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (datain !== 8'h10 + 8'(i)) begin
                n_fail++;
                $display("FAIL full_order_%0d: datain=%h, required %h", i, datain, 8'h10 + 8'(i));
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_streaming();
        in_valid = 1'b1; out_ready = 1'b1; in_amt = 3'd2; in_dir = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_data = 8'h20 + 8'(k);
            step();
            n_checks++;
            if (count !== 3'd1 || datain !== 8'h20 + 8'(k) || shift_amt !== 3'd2) begin
                n_fail++;
                $display("FAIL stream_%0d: count=%0d datain=%h amt=%0d, required 1 %h 2",
                         k, count, datain, shift_amt, 8'h20 + 8'(k));
            end
            $display("stream %0d: count=%0d datain=%h", k, count, datain);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: count=%0d valid=%b, required 0 0", count, out_valid);
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h40 + 8'(i); in_amt = 3'd1; in_dir = 1'b0;
            step();
        end
        n_checks++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_prefill: count=%0d, required 3", count);
        end
        in_data = 8'h43; flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || datain !== 8'h00 || shift_amt !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_clear: count=%0d valid=%b datain=%h amt=%0d, required 0 0 00 0",
                     count, out_valid, datain, shift_amt);
        end
        $display("flush: count=%0d valid=%b", count, out_valid);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'h50 + 8'(i); in_amt = 3'd4; in_dir = 1'b0;
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (count !== 3'd2 || datain !== 8'h50) begin
            n_fail++;
            $display("FAIL refill: count=%0d head=%h, required 2 50", count, datain);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
            datain !== 8'h00 || shift_amt !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d valid=%b ready=%b datain=%h amt=%0d, required 0 0 1 00 0",
                     count, out_valid, in_ready, datain, shift_amt);
        end
        $display("async reset: count=%0d datain=%h", count, datain);
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: count=%0d valid=%b, required 0 0", count, out_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_left_norm();
        test_fill_full();
        test_full_push_pop();
        test_streaming();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_cmd_queue.md
Name: shift_cmd_queue

Overview:
- Upstream feeder for the 8-bit rotate-right barrel shifter.
- Buffers rotate commands {data, amount, direction} in a small FIFO with valid/ready handshakes.
- Normalises left rotates into the equivalent right-rotate amount.
- Presents the head command directly on the shifter's datain/shift_amt inputs, so the shifter result is valid whenever out_valid is high.

Parameters:
- DEPTH, 4, number of command entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear; takes priority over push and pop.
- in_valid  in  1  upstream command valid.
- in_ready  out  1  queue can accept a command (= !full).
- in_data  in  8  data word to rotate.
- in_amt  in  3  rotate amount, 0..7.
- in_dir  in  1  0 = rotate right, 1 = rotate left.
- out_valid  out  1  head command present (= !empty).
- out_ready  in  1  downstream consumed the shifter result this cycle.
- datain  out  8  head data, drives the shifter datain.
- shift_amt  out  3  head normalised right-rotate amount, drives the shifter shift_amt.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count clear to 0.
  - out_valid=0, in_ready=1, datain=8'h00, shift_amt=3'd0.
  - Storage contents are don't-care.
- Push: in_valid && in_ready at a rising edge writes one entry at the write pointer.
- Pop: out_valid && out_ready at a rising edge advances the read pointer.
- Normalisation at write:
  - Stored amount = in_dir ? ((8 - in_amt) mod 8) : in_amt, computed as a 3-bit two's-complement negate.
  - in_dir=1 with in_amt=0 stores 0.
  - Direction is not stored.
- Latency: a push into an empty queue raises out_valid on the next cycle. There is no same-cycle bypass from in_* to datain/shift_amt.
- Output ordering and stability:
  - datain/shift_amt come from the head entry (first-word-fall-through).
  - They hold stable while out_valid=1 and out_ready=0.
  - When empty, they are forced to 8'h00/3'd0.
- Pointers: log2(DEPTH) bits, wrap from DEPTH-1 to 0. count tracks pushes minus pops.
- Full (count==DEPTH):
  - in_ready=0 and in_valid is ignored.
  - A simultaneous pop does not enable a push that cycle, because in_ready is a registered-state function only.
- Empty (count==0):
  - out_valid=0 and out_ready is ignored.
  - Simultaneous push is a normal push.
- Simultaneous push and pop when 0<count<DEPTH: both occur and count is unchanged.
- flush:
  - Next cycle: count=0, pointers=0, out_valid=0, outputs return to zero.
  - A push or pop in the flush cycle is discarded.
- Reset mid-operation: all queued commands are lost. No output glitches beyond the asynchronous clear to reset values.
- out_ready with out_valid=0 has no effect. in_valid may drop without in_ready (no protocol obligation on upstream).

Test Plan:
- Reset then single command: push data=8'hB4, amt=3, dir=0 → next cycle out_valid=1, datain=8'hB4, shift_amt=3 (shifter output 8'h96). Pop → out_valid=0, datain=8'h00.
- Left-rotate normalisation: push {8'h81, 1, dir=1} and {8'h81, 0, dir=1} → shift_amt 7 then 0. Shifter outputs 8'h03 then 8'h81.
- Fill to full with out_ready=0: push 8'h01..8'h04 → count=4, in_ready=0. A 5th push of 8'h05 is ignored. Drain → order 01,02,03,04, and count returns to 0.
- Full with simultaneous push/pop: count=4, in_valid=1 and out_ready=1 in the same cycle → one pop only, count=3. Next cycle the push is accepted and count=4.
- Steady streaming: in_valid=out_ready=1 for 20 cycles with incrementing data → count constant at 1 after the first cycle, no loss or reorder, and pointer wrap is exercised.
- Flush and asynchronous reset: with 3 entries queued, assert flush together with a push → count=0, out_valid=0 next cycle. Refill 2 entries, pull rst_n low mid-cycle → outputs clear immediately, not waiting for a clock edge.
